// File: rtl/ram16_ctrl.sv
// ram16_ctrl: a bank of sixteen WIDTH-bit words behind a one-hot write
// decoder. It has a valid/ready write port, a registered read port, and a
// clear sequencer. The sequencer zeroes all sixteen words after reset and
// again whenever clr is requested.
//
// Ports:
//   clk, rst_n        rising-edge clock; synchronous active-low reset
//   wr_valid/ready    write handshake; a transfer happens on an edge where
//                     both are high
//   wr_addr, wr_data  word index and data for the write
//   rd_valid/ready    read handshake; a transfer happens on an edge where
//                     both are high
//   rd_addr           word index for the read
//   rd_data           registered read data; holds its value between reads
//   rd_data_valid     one-cycle pulse that follows each accepted read
//   clr               request a full clear; ignored while a sweep is running
//   busy              high while the clear sweep runs
module ram16_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_data_valid,
  input  logic             clr,
  output logic             busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [16];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_dv_q, rd_dv_d;
  logic [15:0]      wr_load;
  logic             wr_en, rd_en, access_ok;

  // Handshake readiness: only in READY, and never on a cycle with a clear request.
  always_comb begin
    access_ok = (state_q == READY) && !clr;
    wr_ready  = access_ok;
    rd_ready  = access_ok;
    busy      = (state_q == CLEAR);
    wr_en     = wr_valid && access_ok;
    rd_en     = rd_valid && access_ok;
  end

  // One-hot decode of the write address into per-word load enables.
  always_comb begin
    wr_load = '0;
    if (wr_en) begin
      wr_load[wr_addr] = 1'b1;
    end
  end

  // Next-state logic for the state machine and the sweep counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Read port: the memory is read before this edge's write updates it.
  // This gives read-before-write behaviour on a same-address collision.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_dv_d   = 1'b0;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
      rd_dv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd_dv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_dv_q   <= rd_dv_d;
    end
  end

  // Storage. Reset does not clear the words; the sweep that follows reset
  // does. Writes never happen during CLEAR, because wr_ready is low then.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if ((state_q == CLEAR) && (cnt_q == 4'(i))) begin
          mem_q[i] <= '0;
        end else if (wr_load[i]) begin
          mem_q[i] <= wr_data;
        end
      end
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_dv_q;

endmodule

// File: tb/tb_ram16_ctrl.sv
// Self-checking bench for ram16_ctrl.
// A behavioural model runs on each rising edge. It pushes the expected data
// for every accepted read into a scoreboard queue. A checker on each falling
// edge compares the DUT outputs with the model and pops the queue whenever
// a read result is due.
module tb_ram16_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid, rd_valid, clr;
  logic         wr_ready, rd_ready, rd_data_valid, busy;
  logic [3:0]   wr_addr, rd_addr;
  logic [W-1:0] wr_data, rd_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the block
  logic         m_init = 1'b0;
  logic         m_clear;
  logic [3:0]   m_cnt;
  logic [W-1:0] m_mem [16];
  logic [W-1:0] m_rd_data;
  logic         m_rdv;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  ram16_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .clr           (clr),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic acc;
    if (!rst_n) begin
      m_init    = 1'b1;
      m_clear   = 1'b1;
      m_cnt     = '0;
      m_rd_data = '0;
      m_rdv     = 1'b0;
      exp_q.delete();
    end else if (m_init) begin
      acc   = !m_clear && !clr;
      m_rdv = acc && rd_valid;
      if (m_rdv) begin
        m_rd_data = m_mem[rd_addr];
        exp_q.push_back(m_mem[rd_addr]);
      end
      if (acc && wr_valid) m_mem[wr_addr] = wr_data;
      if (m_clear) begin
        m_mem[m_cnt] = '0;
        if (m_cnt == 4'd15) m_clear = 1'b0;
        m_cnt = m_cnt + 4'd1;
      end else if (clr) begin
        m_clear = 1'b1;
        m_cnt   = '0;
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (m_init) begin
      check("busy", {31'd0, busy}, {31'd0, m_clear});
      check("wr_ready", {31'd0, wr_ready}, {31'd0, !m_clear && !clr});
      check("rd_ready", {31'd0, rd_ready}, {31'd0, !m_clear && !clr});
      check("rd_data_valid", {31'd0, rd_data_valid}, {31'd0, m_rdv});
      check("rd_data_hold", {16'd0, rd_data}, {16'd0, m_rd_data});
      if (m_rdv) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", {16'd0, rd_data}, {16'd0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_valid = 1'b1; rd_addr = a;
    tick();
    rd_valid = 1'b0;
  endtask

  // Count cycles with busy high from now until it drops; bounded.
  task automatic busy_len(input string tag, input int exp_n);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check(tag, n, exp_n);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; clr = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;

    // Reset, then idle until the sweep ends
    tick(); tick();
    rst_n = 1'b1;
    busy_len("reset_sweep_len", 16);
    for (int i = 0; i < 16; i++) rd(4'(i));
    tick();

    // Write every word, then read the words back in reverse order
    for (int i = 0; i < 16; i++) wr(4'(i), W'(16'hA000 + i));
    for (int i = 15; i >= 0; i--) rd(4'(i));
    tick();

    // Read and write the same address on one edge
    wr(4'd5, 16'h1111);
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 16'h2222;
    rd_valid = 1'b1; rd_addr = 4'd5;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    rd(4'd5);
    // Read and write different addresses on one edge
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'h5A5A;
    rd_valid = 1'b1; rd_addr = 4'd5;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    rd(4'd9);
    tick();

    // clr takes priority over a simultaneous write and read
    for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF);
    clr = 1'b1;
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    rd_valid = 1'b1; rd_addr = 4'd3;
    tick();
    clr = 1'b0; rd_valid = 1'b0;
    busy_len("clr_sweep_len", 16);
    wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) rd(4'(i));
    tick();

    // Reset in the middle of a sweep
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 16'hBEEF;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    busy_len("midsweep_reset_len", 16);
    wr_valid = 1'b0;
    rd(4'd0);
    rd(4'd7);
    tick();

    // Hold clr for the whole sweep
    wr(4'd2, 16'hC0DE);
    clr = 1'b1;
    tick();
    busy_len("held_clr_sweep_len", 16);
    check("held_clr_ready_gap", {31'd0, wr_ready}, 32'd0);
    tick();
    check("held_clr_reenter", {31'd0, busy}, 32'd1);
    clr = 1'b0;
    busy_len("held_clr_second_len", 16);
    rd(4'd2);
    tick(); tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
